// File: rtl/blob_centroid_tracker.sv
// Per-marker centroid tracker: accumulates matching-pixel coordinate sums each frame,
// then divides by the pixel count with two 32-step restoring dividers and publishes x/y/z.
module blob_centroid_tracker #(
    parameter int unsigned MIN_PIXELS = 64,
    parameter int unsigned Z_SHIFT    = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        pixel_valid_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        mask_in,
    input  logic        frame_done_in,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic [13:0] z_out,
    output logic        found_out,
    output logic        valid_out,
    output logic        busy_out
);

    typedef enum logic [1:0] {ACCUM, DIVIDE, OUTPUT} state_t;

    state_t      state;
    logic [30:0] sum_x;
    logic [29:0] sum_y;
    logic [19:0] count;
    logic [30:0] sum_x_nxt;
    logic [29:0] sum_y_nxt;
    logic [19:0] count_nxt;
    logic [31:0] sx_add;
    logic [30:0] sy_add;
    logic [20:0] cnt_add;
    logic        pix;

    logic [19:0] snap_count;
    logic [31:0] quo_x, quo_y, quo_x_nxt, quo_y_nxt;
    logic [19:0] rem_x, rem_y, rem_x_nxt, rem_y_nxt;
    logic [20:0] trial_x, trial_y;
    logic [4:0]  iter;
    logic        meets_min;
    logic [19:0] count_shr;
    logic [13:0] z_calc;

    always_comb begin
        pix       = pixel_valid_in & mask_in;
        sx_add    = {1'b0, sum_x} + {21'd0, hcount_in};
        sy_add    = {1'b0, sum_y} + {21'd0, vcount_in};
        cnt_add   = {1'b0, count} + 21'd1;
        sum_x_nxt = sum_x;
        sum_y_nxt = sum_y;
        count_nxt = count;
        if (pix) begin
            // Carry out of each adder means the register would wrap; pin it at all-ones instead.
            sum_x_nxt = sx_add[31]  ? '1 : sx_add[30:0];
            sum_y_nxt = sy_add[30]  ? '1 : sy_add[29:0];
            count_nxt = cnt_add[20] ? '1 : cnt_add[19:0];
        end

        trial_x = {rem_x, quo_x[31]};
        trial_y = {rem_y, quo_y[31]};
        if (trial_x >= {1'b0, snap_count}) begin
            rem_x_nxt = 20'(trial_x - {1'b0, snap_count});
            quo_x_nxt = {quo_x[30:0], 1'b1};
        end else begin
            rem_x_nxt = trial_x[19:0];
            quo_x_nxt = {quo_x[30:0], 1'b0};
        end
        if (trial_y >= {1'b0, snap_count}) begin
            rem_y_nxt = 20'(trial_y - {1'b0, snap_count});
            quo_y_nxt = {quo_y[30:0], 1'b1};
        end else begin
            rem_y_nxt = trial_y[19:0];
            quo_y_nxt = {quo_y[30:0], 1'b0};
        end

        meets_min = ({12'd0, snap_count} >= MIN_PIXELS);
        count_shr = snap_count >> Z_SHIFT;
        z_calc    = (count_shr > 20'd16383) ? '1 : count_shr[13:0];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state      <= ACCUM;
            sum_x      <= '0;
            sum_y      <= '0;
            count      <= '0;
            snap_count <= '0;
            quo_x      <= '0;
            quo_y      <= '0;
            rem_x      <= '0;
            rem_y      <= '0;
            iter       <= '0;
            x_out      <= '0;
            y_out      <= '0;
            z_out      <= '0;
            found_out  <= 1'b0;
            valid_out  <= 1'b0;
            busy_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            // Accumulators keep collecting (or clearing on frame end) regardless of FSM state.
            if (frame_done_in) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end else begin
                sum_x <= sum_x_nxt;
                sum_y <= sum_y_nxt;
                count <= count_nxt;
            end

            case (state)
                ACCUM: begin
                    busy_out <= frame_done_in;
                    if (frame_done_in) begin
                        quo_x      <= {1'b0, sum_x_nxt};
                        quo_y      <= {2'b0, sum_y_nxt};
                        rem_x      <= '0;
                        rem_y      <= '0;
                        snap_count <= count_nxt;
                        iter       <= '0;
                        state      <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    busy_out <= 1'b1;
                    quo_x    <= quo_x_nxt;
                    quo_y    <= quo_y_nxt;
                    rem_x    <= rem_x_nxt;
                    rem_y    <= rem_y_nxt;
                    iter     <= iter + 5'd1;
                    if (iter == 5'd31) state <= OUTPUT;
                end
                OUTPUT: begin
                    // busy stays high through the valid cycle, dropping on the following edge.
                    busy_out  <= 1'b1;
                    valid_out <= 1'b1;
                    found_out <= meets_min;
                    if (meets_min) begin
                        x_out <= quo_x[11:0];
                        y_out <= quo_y[11:0];
                        z_out <= z_calc;
                    end
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: doc/blob_centroid_tracker.md
# blob_centroid_tracker

Converts the per-pixel colour-match stream from the camera front end into the hand/head coordinates (x, y, z) that `game_logic_and_renderer` consumes. It is the producing end of that interface.
- One instance is built per tracked marker: left-bottom, left-top, right-bottom, right-top and head.
- Each frame it accumulates the coordinate sums and pixel count of matching pixels.
- At end of frame it divides the sums by the count with a shared sequential divider, then presents registered coordinates with a one-cycle valid strobe.

## Interface

Parameters:
- `MIN_PIXELS`, default 64: minimum matching-pixel count for a frame to count as a detection.
- `Z_SHIFT`, default 4: right-shift applied to the pixel count to form z.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset, synchronous, active-low.
- `pixel_valid_in`  in  1  the current pixel is in the active camera region.
- `hcount_in`  in  11  pixel column, 0..1023.
- `vcount_in`  in  10  pixel row, 0..767.
- `mask_in`  in  1  the pixel matches the tracked colour; qualified by `pixel_valid_in`.
- `frame_done_in`  in  1  single-cycle pulse marking end of frame.
- `x_out`  out  12  centroid column, zero-extended.
- `y_out`  out  12  centroid row, zero-extended.
- `z_out`  out  14  depth proxy: `min(count >> Z_SHIFT, 16383)`.
- `found_out`  out  1  the last completed frame met `MIN_PIXELS`.
- `valid_out`  out  1  one-cycle pulse when the outputs have been updated.
- `busy_out`  out  1  high in the DIVIDE and OUTPUT states.

## Operation

Accumulators:
- `sum_x` is 31 bits, `sum_y` is 30 bits, `count` is 20 bits.
- Each edge with `pixel_valid_in & mask_in` adds `hcount_in` to `sum_x`, `vcount_in` to `sum_y`, and 1 to `count`.
- All three saturate at all-ones and never wrap.
- Accumulation runs in every state, so the next frame collects while the divider works.

FSM states are ACCUM, DIVIDE and OUTPUT.
- **ACCUM, on `frame_done_in`:**
  - Snapshot `sum_x`, `sum_y` and `count`, including any pixel qualified on that same edge.
  - Clear the accumulators.
  - Go to DIVIDE.
- **DIVIDE:**
  - Two restoring dividers share the divisor `count`; one computes `sum_x/count`, the other `sum_y/count`.
  - Each retires 1 quotient bit per clock over 32 iterations.
  - Quotients are truncated, not rounded.
  - If `count < MIN_PIXELS` (which includes count = 0), the dividers still step for uniform latency. Their results are discarded, so there is no divide-by-zero hazard.
- **OUTPUT (one cycle):**
  - Pulse `valid_out`.
  - If `count >= MIN_PIXELS`: load `x_out` and `y_out` from the quotients, load `z_out`, set `found_out=1`.
  - Otherwise: set `found_out=0` and hold `x_out`, `y_out` and `z_out` at their previous values.
  - Return to ACCUM.
- **`frame_done_in` while in DIVIDE or OUTPUT:** that frame is dropped. Accumulators clear as usual, the division in progress is unaffected, and no extra `valid_out` is produced.

Reset (`rst_in == 0` at an edge):
- State goes to ACCUM.
- Accumulators, snapshot registers and divider registers clear.
- All outputs are 0.
- A reset during DIVIDE aborts the division and produces no `valid_out`.

## Timing

- Outputs are registered, with no combinational path from inputs to outputs.
- The edge that samples `frame_done_in` is edge 0.
  - Divider iterations occur on edges 1..32.
  - The outputs and `valid_out` update on edge 33, so `valid_out` is high for exactly the cycle after edge 33.
- `busy_out` is high from after edge 0 through the `valid_out` cycle.
- Frames must be at least 35 clocks apart to avoid drops; the camera timing guarantees far more.
- `x_out`, `y_out`, `z_out` and `found_out` are stable between `valid_out` pulses, so consumers may sample them asynchronously to `valid_out`.

## Test plan

- **8x8 blob:** mask set at columns 100..107, rows 200..207, then `frame_done_in` → at edge 33 `valid_out` pulses once with x=103, y=203, z=4, `found_out=1`.
- **Below threshold:** 63 matching pixels following a good frame → `valid_out` pulses, `found_out=0`, and x, y and z keep the previous frame's values. A frame with no matching pixels gives the same result and no X/garbage on the outputs.
- **Full frame:** all 1024x768 pixels match → x=511, y=383, z saturates to 16383, `found_out=1`, and no accumulator wrap.
- **Boundary pixel:** a matching pixel (hcount=500, vcount=10) on the same edge as `frame_done_in`, with a 64-pixel blob centred elsewhere → that pixel is counted in the closing frame, and the next frame's count starts at 0.
- **Overlapping frames:** a second `frame_done_in` at edge 10 → exactly one `valid_out`, at edge 33, carrying frame 1's results. Frame 2 is dropped, and the accumulators are clear after edge 10.
- **Reset mid-divide:** `rst_in` low at edge 15 → all outputs 0 and no `valid_out`. A subsequent good frame produces correct results with normal latency.
